pc_gen: RTL

Parametrised program-counter generator for the single-cycle MIPS core. It owns the PC register and computes the next PC internally from the instruction fields: sequential, conditional branch, j, jal and jr. It also keeps a depth-parametrised return-address stack (RAS) that checks jr-to-$ra returns against the recorded call history and flags mismatches for debug and verification. It sits between the IM address port and the controller/ALU, and replaces the external next-PC mux chain.

---
 rtl/pc_gen.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the single-cycle MIPS core.
// Owns the PC register, selects the next PC from the decoded instruction
// fields, and tracks call history in a small circular return-address stack
// so that jr $ra returns can be cross-checked against the matching jal.
module pc_gen #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(32'h0000_3000),
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [2:0]                   npc_sel,
  input  logic                         zero,
  input  logic [15:0]                  imm16,
  input  logic [25:0]                  instr_index,
  input  logic [WIDTH-1:0]             jr_target,
  input  logic                         jr_is_ra,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_plus4,
  output logic [WIDTH-1:0]             next_pc,
  output logic                         pc_misalign,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic [WIDTH-1:0]             ras_top,
  output logic                         ras_mismatch,
  output logic                         ras_underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned EXT_W = WIDTH - 18;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

  // npc_sel encodings; anything not listed falls back to sequential
  localparam logic [2:0] SEL_SEQ = 3'b000;
  localparam logic [2:0] SEL_BEQ = 3'b001;
  localparam logic [2:0] SEL_J   = 3'b010;
  localparam logic [2:0] SEL_JAL = 3'b011;
  localparam logic [2:0] SEL_JR  = 3'b100;

  logic [WIDTH-1:0] br_offset;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] jmp_target;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] ras_ptr_nxt;
  logic [PTR_W-1:0] push_idx;
  logic [CNT_W-1:0] ras_count_nxt;
  logic             mismatch_nxt;
  logic             underflow_nxt;

  logic is_jal;
  logic is_ret;
  logic ras_empty;
  logic do_push;
  logic do_pop;
  logic do_underflow;

  // Target arithmetic: link value, word-scaled signed branch offset, pseudo-direct jump
  assign pc_plus4   = pc + WIDTH'(4);
  assign br_offset  = {{EXT_W{imm16[15]}}, imm16, 2'b00};
  assign br_target  = pc_plus4 + br_offset;
  assign jmp_target = {pc_plus4[WIDTH-1:28], instr_index, 2'b00};

  // Misalignment can only enter through jr; it is flagged, never repaired
  assign pc_misalign = (pc[1:0] != 2'b00);

  // Next-PC selection; still evaluated while stalled
  always_comb begin
    next_pc = pc_plus4;
    case (npc_sel)
      SEL_SEQ: next_pc = pc_plus4;
      SEL_BEQ: next_pc = zero ? br_target : pc_plus4;
      SEL_J:   next_pc = jmp_target;
      SEL_JAL: next_pc = jmp_target;
      SEL_JR:  next_pc = jr_target;
      default: next_pc = pc_plus4;
    endcase
  end

  // RAS operation decode; a stalled instruction has no side effects
  assign is_jal       = (npc_sel == SEL_JAL);
  assign is_ret       = (npc_sel == SEL_JR) && jr_is_ra;
  assign ras_empty    = (ras_count == '0);
  assign do_push      = !stall && is_jal;
  assign do_pop       = !stall && is_ret && !ras_empty;
  assign do_underflow = !stall && is_ret && ras_empty;
  assign push_idx     = ras_ptr + PTR_W'(1);

  // RAS next-state: pointer tracks the top entry; a push when full wraps onto the oldest
  always_comb begin
    ras_ptr_nxt   = ras_ptr;
    ras_count_nxt = ras_count;
    mismatch_nxt  = 1'b0;
    underflow_nxt = 1'b0;
    if (do_push) begin
      ras_ptr_nxt = push_idx;
      if (ras_count != DEPTH_CNT) begin
        ras_count_nxt = ras_count + CNT_W'(1);
      end
    end else if (do_pop) begin
      ras_ptr_nxt   = ras_ptr - PTR_W'(1);
      ras_count_nxt = ras_count - CNT_W'(1);
      mismatch_nxt  = (ras_mem[ras_ptr] != jr_target);
    end else if (do_underflow) begin
      underflow_nxt = 1'b1;
    end
  end

  // PC and RAS control registers; reset overrides stall
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      ras_ptr       <= '0;
      ras_count     <= '0;
      ras_mismatch  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      if (!stall) begin
        pc <= next_pc;
      end
      ras_ptr       <= ras_ptr_nxt;
      ras_count     <= ras_count_nxt;
      ras_mismatch  <= mismatch_nxt;
      ras_underflow <= underflow_nxt;
    end
  end

  // RAS storage; contents are left as-is on reset since count gates visibility
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      ras_mem[push_idx] <= pc_plus4;
    end
  end

  // Top-of-stack view, zero when nothing has been recorded
  assign ras_top = ras_empty ? '0 : ras_mem[ras_ptr];

endmodule
